rr_mux_8_to_1: RTL and testbench

Sequential 8-to-1 collector that merges eight valid/ready source channels onto one registered output channel. It tags each output word with the 3-bit index of the source channel that supplied it. It is the gathering counterpart of the 3-to-8 demultiplexer path: the demux steers one stream out to eight sinks by a select, and this block merges eight streams back into one stream and produces that select. A round-robin scheduler keeps the merge fair.

---
 rtl/rr_mux_pkg.sv | 42 ++++
 rtl/rr_arb_8.sv | 50 +++++
 rtl/rr_mux_8_to_1.sv | 82 ++++++++
 tb/tb_rr_mux_8_to_1.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_pkg.sv
// Shared definitions for the 8-to-1 round-robin collector.
//   N_CH / SEL_W   : channel count and width of a channel index
//   pick_t         : result of a cyclic priority search (found flag + index)
//   onehot_to_idx  : encode a one-hot (or zero) vector to its bit index
//   rr_pick        : first set request at or after ptr, searching cyclically
package rr_mux_pkg;

  localparam int N_CH  = 8;
  localparam int SEL_W = 3;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_CH-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (oh[i]) idx = idx | SEL_W'(i);
    end
    return idx;
  endfunction

  // Offsets are walked from farthest to nearest so the nearest hit is the
  // last assignment; no early exit is needed.
  function automatic pick_t rr_pick(input logic [N_CH-1:0] req,
                                    input logic [SEL_W-1:0] ptr);
    pick_t            r;
    logic [SEL_W-1:0] idx;
    r = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx]) begin
        r.found = 1'b1;
        r.idx   = idx;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arb_8.sv
// Eight-way arbiter holding the round-robin pointer.
//   clk, rst      : clock, synchronous active-high reset (pointer to 0)
//   req           : per-channel requests
//   advance       : a grant was taken this cycle; pointer moves past it
//   grant_onehot  : one-hot grant (zero when nothing requests)
//   grant_idx     : index of the granted channel
//   found         : some channel requests
// Build option RR_MUX_FIXED_PRIO_EN: no pointer, channel 0 always highest
// priority.
module rr_arb_8
  import rr_mux_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   req,
  input  logic              advance,
  output logic [N_CH-1:0]   grant_onehot,
  output logic [SEL_W-1:0]  grant_idx,
  output logic              found
);

  pick_t pick;

`ifdef RR_MUX_FIXED_PRIO_EN
  logic unused_arb_inputs;
  assign unused_arb_inputs = ^{clk, rst, advance};
  assign pick = rr_pick(req, '0);
`else
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] ptr_d;

  assign pick = rr_pick(req, ptr_q);

  // 3-bit add wraps index 7 back to 0.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) ptr_d = pick.idx + SEL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

  assign found        = pick.found;
  assign grant_onehot = pick.found ? (N_CH'(1) << pick.idx) : '0;
  assign grant_idx    = onehot_to_idx(grant_onehot);

endmodule

// File: rtl/rr_mux_8_to_1.sv
// 8-to-1 valid/ready collector with a one-entry registered output buffer.
// Each output word carries the index of the channel that supplied it.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : per-channel request
//   in_data    : packed channel data, channel i at [i*W +: W]
//   in_ready   : one-hot accept (zero while stalled, idle or in reset)
//   out_valid  : output buffer holds a word
//   out_data   : buffered word
//   out_sel    : source channel of the buffered word
//   out_ready  : downstream takes the word this cycle
// Build option RR_MUX_FIXED_PRIO_EN: fixed priority instead of round-robin.
module rr_mux_8_to_1
  import rr_mux_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH-1:0]     in_valid,
  input  logic [N_CH*W-1:0]   in_data,
  output logic [N_CH-1:0]     in_ready,
  output logic                out_valid,
  output logic [W-1:0]        out_data,
  output logic [SEL_W-1:0]    out_sel,
  input  logic                out_ready
);

  logic [N_CH-1:0]  grant_onehot;
  logic [SEL_W-1:0] grant_idx;
  logic             found;
  logic             free;
  logic             xfer;

  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_sel_q,   out_sel_d;

  rr_arb_8 u_arb (
    .clk          (clk),
    .rst          (rst),
    .req          (in_valid),
    .advance      (xfer),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .found        (found)
  );

  // Buffer can take a word when empty or when its word leaves this cycle.
  assign free     = !out_valid_q || out_ready;
  assign in_ready = (free && found && !rst) ? grant_onehot : '0;
  assign xfer     = |in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(grant_idx)*W +: W];
      out_sel_d   = grant_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_8_to_1.sv
module tb_rr_mux_8_to_1;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [7:0]     in_valid = '0;
  logic [8*W-1:0] in_data;
  logic [7:0]     in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [2:0]     out_sel;
  logic           out_ready = 1'b0;

  logic [W-1:0]   d [8];

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic        m_valid = 1'b0;
  logic [7:0]  m_data  = '0;
  logic [2:0]  m_sel   = '0;
  logic [2:0]  m_ptr   = '0;
  logic [10:0] sb_q [$];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 8; i++) in_data[i*W +: W] = d[i];
  end

  rr_mux_8_to_1 #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check the DUT against the model mid-cycle,
  // then advance the model across the next rising edge.
  task automatic step(input logic [7:0] v, input logic ro);
    logic       free;
    logic       fnd;
    logic [2:0] g;
    logic [2:0] start;
    logic [2:0] idx;
    logic [7:0] exp_rdy;
    logic [10:0] e;
    in_valid  = v;
    out_ready = ro;
    @(negedge clk);
`ifdef RR_MUX_FIXED_PRIO_EN
    start = 3'd0;
`else
    start = m_ptr;
`endif
    fnd = 1'b0;
    g   = '0;
    for (int k = 0; k < 8; k++) begin
      idx = start + 3'(k);
      if (!fnd && v[idx]) begin
        fnd = 1'b1;
        g   = idx;
      end
    end
    free    = !m_valid || ro;
    exp_rdy = (free && fnd && !rst) ? (8'd1 << g) : 8'd0;
    chk("in_ready",  in_ready,  exp_rdy);
    chk("out_valid", out_valid, m_valid);
    chk("out_sel",   out_sel,   m_sel);
    chk("out_data",  out_data,  m_data);
    if (rst) begin
      sb_q.delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_sel   = '0;
      m_ptr   = '0;
    end else begin
      if (m_valid && ro) begin
        if (sb_q.size() == 0) begin
          chk("sb_empty", 32'd0, 32'd1);
        end else begin
          e = sb_q.pop_front();
          chk("sb_sel",  out_sel,  e[10:8]);
          chk("sb_data", out_data, e[7:0]);
        end
      end
      if (exp_rdy != 0) begin
        sb_q.push_back({g, d[g]});
        m_valid = 1'b1;
        m_sel   = g;
        m_data  = d[g];
        m_ptr   = g + 3'd1;
      end else if (ro) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) d[i] = 8'h10 + 8'(i);

    // Reset, then idle with out_ready high
    rst = 1'b1;
    step(8'h00, 1'b1);
    step(8'hFF, 1'b1);
    rst = 1'b0;
    repeat (10) step(8'h00, 1'b1);

    // Single channel 3
    d[3] = 8'hA5;
    step(8'h08, 1'b1);
    chk("single_sel",  out_sel,  32'd3);
    chk("single_data", out_data, 32'hA5);
    // Pointer now past channel 3
    step(8'hFF, 1'b1);
    step(8'h00, 1'b1);
    d[3] = 8'h13;

    // All channels continuously from a fresh pointer: 0..7 then wrap to 0
    rst = 1'b1;
    step(8'h00, 1'b1);
    rst = 1'b0;
    repeat (10) step(8'hFF, 1'b1);
    step(8'h00, 1'b1);

    // Backpressure with sel=2 buffered
    rst = 1'b1;
    step(8'h00, 1'b1);
    rst = 1'b0;
    repeat (3) step(8'hFF, 1'b1);
    chk("bp_sel", out_sel, 32'd2);
    repeat (5) step(8'hFF, 1'b0);
    step(8'hFF, 1'b1);
    chk("bp_refill_sel", out_sel, 32'd3);
    step(8'h00, 1'b1);

    // Reset while sel=5 is buffered
    rst = 1'b1;
    step(8'h00, 1'b1);
    rst = 1'b0;
    repeat (6) step(8'hFF, 1'b1);
    chk("mid_sel", out_sel, 32'd5);
    rst = 1'b1;
    step(8'hFF, 1'b1);
    rst = 1'b0;
    step(8'hFF, 1'b1);
    chk("post_rst_sel", out_sel, 32'd0);
    step(8'h00, 1'b1);

    // Channels 0 and 7 both held
    repeat (6) step(8'h81, 1'b1);
    step(8'h00, 1'b1);

    // Mixed random traffic
    for (int i = 0; i < 8; i++) d[i] = 8'($urandom);
    for (int n = 0; n < 60; n++) begin
      if (n % 7 == 0) d[n % 8] = 8'($urandom);
      step(8'($urandom), ($urandom_range(0, 3) != 0));
    end
    repeat (2) step(8'h00, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
